// File: rtl/fish_sprite_renderer.sv
// Fish sprite reader: latches the sprite position at frame boundaries,
// turns the VGA scan coordinates into a sprite ROM address, and lines the
// returned ROM colour up with the scan pipeline. Pixels in the key colour
// are dropped, which makes them transparent.
//
// Position handshake: load_req is a single-cycle pulse with no ready side.
// Each pulse overwrites the pending set, so the last request wins.
// The pending set moves into the active set on the next frame_tick, and
// load_ack pulses for one cycle after that commit. When load_req and
// frame_tick arrive together, the new inputs commit at once.
module fish_sprite_renderer #(
    parameter int          SPR_W     = 32,
    parameter int          SPR_H     = 16,
    parameter logic [11:0] KEY_COLOR = 12'h0F0,
    parameter int          ROM_LAT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic [9:0]  pos_x_in,
    input  logic [9:0]  pos_y_in,
    input  logic        dir_left_in,
    input  logic        vis_in,
    input  logic        load_req,
    output logic        load_ack,
    output logic [3:0]  rom_row,
    output logic [4:0]  rom_col,
    input  logic [11:0] rom_data,
    output logic        pixel_on,
    output logic [11:0] pixel_rgb
);

    typedef struct packed {
        logic [9:0] pos_x;
        logic [9:0] pos_y;
        logic       dir;
        logic       vis;
    } spr_set_t;

    typedef enum logic {
        PEND_EMPTY = 1'b0,
        PEND_FULL  = 1'b1
    } pend_state_e;

    pend_state_e pend_state_q, pend_state_d;
    spr_set_t    pend_q, pend_d;
    spr_set_t    act_q, act_d;
    spr_set_t    req_set;
    logic        load_ack_q, load_ack_d;

    logic [ROM_LAT-1:0] hit_pipe_q;
    logic [ROM_LAT-1:0] von_pipe_q;
    logic               pixel_on_q, pixel_on_d;
    logic [11:0]        pixel_rgb_q, pixel_rgb_d;

    logic [10:0] x_ext, y_ext, ax_ext, ay_ext;
    logic [4:0]  dx_lo;
    logic [3:0]  dy_lo;
    logic        hit;

    assign req_set = '{pos_x: pos_x_in, pos_y: pos_y_in, dir: dir_left_in, vis: vis_in};

    // Handshake next state: capture requests into pending and commit on frame_tick.
    always_comb begin
        pend_state_d = pend_state_q;
        pend_d       = pend_q;
        act_d        = act_q;
        load_ack_d   = 1'b0;
        if (frame_tick && load_req) begin
            pend_d       = req_set;
            act_d        = req_set;
            load_ack_d   = 1'b1;
            pend_state_d = PEND_EMPTY;
        end else if (frame_tick && (pend_state_q == PEND_FULL)) begin
            act_d        = pend_q;
            load_ack_d   = 1'b1;
            pend_state_d = PEND_EMPTY;
        end else if (load_req) begin
            pend_d       = req_set;
            pend_state_d = PEND_FULL;
        end
    end

    // Handshake registers: pending set, active set and the ack pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_state_q <= PEND_EMPTY;
            pend_q       <= '0;
            act_q        <= '0;
            load_ack_q   <= 1'b0;
        end else begin
            pend_state_q <= pend_state_d;
            pend_q       <= pend_d;
            act_q        <= act_d;
            load_ack_q   <= load_ack_d;
        end
    end

    // Hit test and ROM address. The compares are widened to 11 bits so that
    // a sprite placed near 1023 cannot wrap around to column 0.
    always_comb begin
        x_ext  = {1'b0, x};
        y_ext  = {1'b0, y};
        ax_ext = {1'b0, act_q.pos_x};
        ay_ext = {1'b0, act_q.pos_y};
        dx_lo  = x[4:0] - act_q.pos_x[4:0];
        dy_lo  = y[3:0] - act_q.pos_y[3:0];
        hit    = act_q.vis
               && (x_ext >= ax_ext) && (x_ext < ax_ext + 11'(SPR_W))
               && (y_ext >= ay_ext) && (y_ext < ay_ext + 11'(SPR_H));
        rom_row = dy_lo;
        rom_col = act_q.dir ? (5'(SPR_W - 1) - dx_lo) : dx_lo;
    end

    // Delay hit and video_on by the ROM latency so they arrive with rom_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_pipe_q <= '0;
            von_pipe_q <= '0;
        end else begin
            hit_pipe_q[0] <= hit;
            von_pipe_q[0] <= video_on;
            for (int i = 1; i < ROM_LAT; i++) begin
                hit_pipe_q[i] <= hit_pipe_q[i-1];
                von_pipe_q[i] <= von_pipe_q[i-1];
            end
        end
    end

    // Output next state: drop off-sprite, blanked and key-coloured pixels.
    always_comb begin
        pixel_on_d  = hit_pipe_q[ROM_LAT-1] & von_pipe_q[ROM_LAT-1]
                    & (rom_data != KEY_COLOR);
        pixel_rgb_d = pixel_on_d ? rom_data : 12'h000;
    end

    // Output register feeding the display mux.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_on_q  <= 1'b0;
            pixel_rgb_q <= 12'h000;
        end else begin
            pixel_on_q  <= pixel_on_d;
            pixel_rgb_q <= pixel_rgb_d;
        end
    end

    assign load_ack  = load_ack_q;
    assign pixel_on  = pixel_on_q;
    assign pixel_rgb = pixel_rgb_q;

endmodule

// File: tb/tb_fish_sprite_renderer.sv
module tb_fish_sprite_renderer;

    logic        clk;
    logic        reset;
    logic [9:0]  x, y;
    logic        video_on;
    logic        frame_tick;
    logic [9:0]  pos_x_in, pos_y_in;
    logic        dir_left_in, vis_in, load_req;
    logic        load_ack;
    logic [3:0]  rom_row;
    logic [4:0]  rom_col;
    logic [11:0] rom_data;
    logic        pixel_on;
    logic [11:0] pixel_rgb;

    fish_sprite_renderer dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
        .frame_tick(frame_tick), .pos_x_in(pos_x_in), .pos_y_in(pos_y_in),
        .dir_left_in(dir_left_in), .vis_in(vis_in), .load_req(load_req),
        .load_ack(load_ack), .rom_row(rom_row), .rom_col(rom_col),
        .rom_data(rom_data), .pixel_on(pixel_on), .pixel_rgb(pixel_rgb)
    );

    // Clock and ROM model (registered address, one cycle of latency).
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] mem [512];
    initial rom_data = 12'h000;
    always @(posedge clk) rom_data <= mem[{rom_row, rom_col}];

    // Scoreboard and reference-model state.
    int n_cmp = 0;
    int n_err = 0;
    logic [12:0] exp_q[$];
    int m_px, m_py, m_ax, m_ay;
    bit m_pdir, m_pvis, m_pvalid, m_adir, m_avis, m_ack_exp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_px = 0; m_py = 0; m_pdir = 0; m_pvis = 0; m_pvalid = 0;
        m_ax = 0; m_ay = 0; m_adir = 0; m_avis = 0; m_ack_exp = 0;
    endfunction

    // Image-level view: which sprite pixel (if any) sits under the beam.
    function automatic logic [12:0] ref_pixel();
        int sx, sy, c;
        logic [11:0] w;
        sx = int'(x) - m_ax;
        sy = int'(y) - m_ay;
        if (!m_avis || !video_on || sx < 0 || sx >= 32 || sy < 0 || sy >= 16)
            return 13'd0;
        c = m_adir ? 31 - sx : sx;
        w = mem[sy * 32 + c];
        if (w == 12'h0F0) return 13'd0;
        return {1'b1, w};
    endfunction

    task automatic set_scan(input int xx, input int yy);
        x = 10'(xx);
        y = 10'(yy);
        video_on = (xx < 640) && (yy < 480);
    endtask

    task automatic request(input int px, input int py, input bit dir, input bit vis);
        pos_x_in = 10'(px);
        pos_y_in = 10'(py);
        dir_left_in = dir;
        vis_in = vis;
        load_req = 1'b1;
    endtask

    // One clock: check at negedge, update the model at posedge, drop pulses.
    task automatic tick();
        int sx, sy;
        logic [12:0] e;
        @(negedge clk);
        chk("load_ack", 32'(load_ack), 32'(m_ack_exp));
        sx = int'(x) - m_ax;
        sy = int'(y) - m_ay;
        if (m_avis && sx >= 0 && sx < 32 && sy >= 0 && sy < 16) begin
            chk("rom_row", 32'(rom_row), 32'(sy));
            chk("rom_col", 32'(rom_col), 32'(m_adir ? 31 - sx : sx));
        end
        exp_q.push_back(ref_pixel());
        if (exp_q.size() > 2) begin
            e = exp_q.pop_front();
            chk("pixel_on", 32'(pixel_on), 32'(e[12]));
            chk("pixel_rgb", 32'(pixel_rgb), 32'(e[11:0]));
        end
        @(posedge clk);
        m_ack_exp = 0;
        if (frame_tick && load_req) begin
            m_ax = int'(pos_x_in); m_ay = int'(pos_y_in);
            m_adir = dir_left_in; m_avis = vis_in;
            m_pvalid = 0; m_ack_exp = 1;
        end else if (frame_tick && m_pvalid) begin
            m_ax = m_px; m_ay = m_py; m_adir = m_pdir; m_avis = m_pvis;
            m_pvalid = 0; m_ack_exp = 1;
        end else if (load_req) begin
            m_px = int'(pos_x_in); m_py = int'(pos_y_in);
            m_pdir = dir_left_in; m_pvis = vis_in; m_pvalid = 1;
        end
        #1;
        load_req = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic reset_tail();
        @(posedge clk);
        #1;
        chk("rst_pixel_on", 32'(pixel_on), 32'd0);
        chk("rst_pixel_rgb", 32'(pixel_rgb), 32'd0);
        chk("rst_load_ack", 32'(load_ack), 32'd0);
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        exp_q.push_back(13'd0);
        exp_q.push_back(13'd0);
    endtask

    int acks;
    int xx, yy;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 12'($urandom_range(0, 4095));
        mem[0] = 12'hABC;
        mem[5] = 12'h0F0;
        mem[6] = 12'h88F;
        mem[9 * 32 + 19] = 12'h123;

        reset = 1'b1; load_req = 0; frame_tick = 0;
        pos_x_in = 0; pos_y_in = 0; dir_left_in = 0; vis_in = 0;
        set_scan(0, 0);
        @(posedge clk);
        reset_tail();

        // First load, commit 10 cycles later; nothing visible before commit.
        set_scan(100, 50);
        repeat (3) tick();
        request(100, 50, 0, 1);
        tick();
        repeat (9) begin
            tick();
            chk("no_pix_pre_commit", 32'(pixel_on), 32'd0);
        end
        frame_tick = 1'b1;
        tick();
        chk("ack_pulse", 32'(load_ack), 32'd1);
        tick();
        chk("ack_once", 32'(load_ack), 32'd0);

        // Corner addressing, dir=0.
        set_scan(100, 50); #1;
        chk("row_at_origin", 32'(rom_row), 32'd0);
        chk("col_at_origin", 32'(rom_col), 32'd0);
        tick(); tick();
        chk("on_at_origin", 32'(pixel_on), 32'd1);
        chk("rgb_at_origin", 32'(pixel_rgb), 32'hABC);
        set_scan(131, 65); #1;
        chk("row_far_corner", 32'(rom_row), 32'd15);
        chk("col_far_corner", 32'(rom_col), 32'd31);
        tick(); tick();
        set_scan(132, 50); tick(); tick();
        chk("off_right_edge", 32'(pixel_on), 32'd0);
        set_scan(99, 50); tick(); tick();
        chk("off_left_edge", 32'(pixel_on), 32'd0);

        // Mirrored, committed in the same cycle as the request.
        request(100, 50, 1, 1);
        frame_tick = 1'b1;
        tick(); tick();
        set_scan(100, 53); #1;
        chk("mirror_row", 32'(rom_row), 32'd3);
        chk("mirror_col_left", 32'(rom_col), 32'd31);
        set_scan(131, 53); #1;
        chk("mirror_col_right", 32'(rom_col), 32'd0);
        tick(); tick();

        // Transparency key.
        request(100, 50, 0, 1);
        frame_tick = 1'b1;
        tick();
        set_scan(105, 50); tick(); tick();
        chk("key_pixel_on", 32'(pixel_on), 32'd0);
        chk("key_pixel_rgb", 32'(pixel_rgb), 32'd0);
        set_scan(106, 50); tick(); tick();
        chk("opaque_pixel_on", 32'(pixel_on), 32'd1);
        chk("opaque_pixel_rgb", 32'(pixel_rgb), 32'h88F);

        // Last request wins, single ack.
        acks = 0;
        request(10, 10, 0, 1);
        tick(); acks += int'(load_ack);
        repeat (3) begin tick(); acks += int'(load_ack); end
        request(200, 300, 0, 1);
        tick(); acks += int'(load_ack);
        repeat (3) begin tick(); acks += int'(load_ack); end
        frame_tick = 1'b1;
        tick(); acks += int'(load_ack);
        repeat (4) begin tick(); acks += int'(load_ack); end
        chk("single_ack", 32'(acks), 32'd1);
        set_scan(200, 300); #1;
        chk("last_wins_row", 32'(rom_row), 32'd0);
        chk("last_wins_col", 32'(rom_col), 32'd0);
        tick(); tick();
        chk("last_wins_on", 32'(pixel_on), 32'd1);
        request(300, 200, 0, 1);
        frame_tick = 1'b1;
        tick();
        chk("ack_same_cycle", 32'(load_ack), 32'd1);
        frame_tick = 1'b1;
        tick(); tick();
        chk("no_ack_idle_tick", 32'(load_ack), 32'd0);

        // Visible-area edge clipping.
        request(620, 470, 0, 1);
        frame_tick = 1'b1;
        tick(); tick();
        set_scan(639, 479); tick(); tick();
        chk("edge_on", 32'(pixel_on), 32'd1);
        chk("edge_rgb", 32'(pixel_rgb), 32'h123);
        set_scan(640, 479); tick(); tick();
        chk("edge_clipped", 32'(pixel_on), 32'd0);

        // Randomized traffic around the active sprite.
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 7) == 0)
                request(int'($urandom_range(0, 790)), int'($urandom_range(0, 520)),
                        1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) frame_tick = 1'b1;
            xx = m_ax + int'($urandom_range(0, 40)) - 4;
            yy = m_ay + int'($urandom_range(0, 22)) - 3;
            if (xx < 0) xx = 0;
            if (xx > 799) xx = 799;
            if (yy < 0) yy = 0;
            if (yy > 524) yy = 524;
            set_scan(xx, yy);
            tick();
        end

        // Asynchronous reset while a pixel is being shown.
        request(620, 470, 0, 1);
        frame_tick = 1'b1;
        tick(); tick();
        set_scan(639, 479);
        repeat (3) tick();
        chk("pre_reset_on", 32'(pixel_on), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_drop_on", 32'(pixel_on), 32'd0);
        chk("async_drop_rgb", 32'(pixel_rgb), 32'd0);
        reset_tail();
        repeat (4) tick();
        frame_tick = 1'b1;
        tick();
        repeat (3) tick();
        chk("hidden_after_reset", 32'(pixel_on), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fish_sprite_renderer.md
Name: fish_sprite_renderer

Overview:
- Reader side of the 32x16, 12-bit fish sprite ROMs. The ROM is addressed by {row[3:0], col[4:0]}, registers its address internally, and has 1-cycle read latency.
- Takes the VGA scan coordinates each clock and computes the sprite-relative ROM address from a frame-latched sprite position. Supports horizontal mirroring.
- Aligns ROM data with the scan pipeline and removes the key colour 12'h0F0 (transparency).
- Drives pixel_on/pixel_rgb to the display mux. Position updates use a request/acknowledge handshake and take effect only at frame boundaries, which prevents tearing.

Parameters:
- SPR_W, 32, sprite width in pixels; must equal 2^(rom_col width).
- SPR_H, 16, sprite height in pixels; must equal 2^(rom_row width).
- KEY_COLOR, 12'h0F0, transparent colour; matching pixels are suppressed.
- ROM_LAT, 1, ROM read latency in clocks; the delay line depth.

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  asynchronous, active-high reset
- x  in  10  current scan column, 0..799
- y  in  10  current scan row, 0..524
- video_on  in  1  high inside the 640x480 visible area
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- pos_x_in  in  10  requested sprite left edge
- pos_y_in  in  10  requested sprite top edge
- dir_left_in  in  1  requested orientation; 1 mirrors horizontally
- vis_in  in  1  requested visibility
- load_req  in  1  pulse: capture the pos/dir/vis inputs into the pending set
- load_ack  out  1  one-cycle pulse when the pending set is committed to the active set
- rom_row  out  4  ROM row address
- rom_col  out  5  ROM column address
- rom_data  in  12  ROM colour output, valid ROM_LAT clocks after the address
- pixel_on  out  1  sprite pixel is opaque at the pixel being output
- pixel_rgb  out  12  sprite colour; 12'h000 when pixel_on=0

Behaviour:
- Reset (async):
  - pending and active sets cleared: pos=0, dir=0, vis=0.
  - pend_valid=0, load_ack=0, pixel_on=0, pixel_rgb=0, delay line cleared.
  - Sprite is invisible until the first commit.
- Handshake:
  - On a load_req cycle, pending <= the input set and pend_valid <= 1. A later load_req before commit overwrites pending (last request wins).
  - Commit: on a frame_tick cycle with pend_valid=1, active <= pending, pend_valid <= 0, and load_ack=1 in the next cycle.
  - load_req and frame_tick in the same cycle: the new inputs commit directly, and load_ack pulses next cycle.
  - frame_tick with pend_valid=0: no change, no ack.
- Hit test (combinational, stage 0):
  - dx = {1'b0,x} - {1'b0,ax}; dy = {1'b0,y} - {1'b0,ay}, both 11-bit.
  - hit = vis and x >= ax and x < ax+SPR_W and y >= ay and y < ay+SPR_H.
  - Comparisons are 11-bit, so ax+32 past 1023 does not wrap.
- Address:
  - rom_row = dy[3:0].
  - rom_col = dir ? (SPR_W-1 - dx[4:0]) : dx[4:0].
  - Combinational from x, y and the active set; don't-care when hit=0.
- Alignment: hit and video_on pass through a ROM_LAT-deep register chain, so they arrive with rom_data.
- Output register:
  - pixel_on <= hit_d & von_d & (rom_data != KEY_COLOR).
  - pixel_rgb <= pixel_on_next ? rom_data : 12'h000.
- Latency: coordinates at cycle n produce output at cycle n+ROM_LAT+1, which is n+2 by default. The upstream mux delays its own layers by 2 to match.
- Active-set changes only occur at frame_tick, i.e. during blanking. A sprite straddling the visible edge is clipped by video_on.
- Reset mid-frame: outputs drop immediately. The sprite stays hidden until a load_req plus frame_tick has committed.

Test Plan:
- Reset, then load_req with pos=(100,50), vis=1, dir=0, followed by frame_tick 10 cycles later. Required: load_ack high exactly one cycle after frame_tick, and no pixel_on before the commit.
- Active (100,50), dir=0, scan (100,50). Required: rom_row=0 and rom_col=0 the same cycle; pixel_on/pixel_rgb 2 cycles later equal to the ROM word at address 0. Scanning (131,65) gives row=15, col=31. Scanning (132,50) and (99,50) give pixel_on=0.
- dir=1, scan (100,53). Required: rom_col=31, rom_row=3. Scan (131,53) gives rom_col=0.
- ROM model returns 12'h0F0 for an in-sprite pixel. Required: pixel_on=0 and pixel_rgb=0. The ROM model returns 12'h88F. Required: pixel_on=1 and pixel_rgb=12'h88F.
- Two load_req pulses, (10,10) then (200,300), before one frame_tick. Required: the active position becomes (200,300) with a single load_ack. load_req together with frame_tick commits in that cycle.
- Position (620,470), scan (639,479) with video_on=1, then (640,479) with video_on=0. Required: pixel_on 1 (if opaque) then 0. Assert reset at the same time and check that pixel_on drops without waiting for a clock edge.
